id_stage: RTL and testbench

//  Decode stage directly downstream of instruction fetch; consumes the IF/ID outputs (instruction, pc, pc+4, ready, misalign flag).

---
 rtl/riscv_defs.sv | 88 ++++++++
 rtl/reg_file.sv | 36 +++
 rtl/id_stage.sv | 227 ++++++++++++++++++++++
 tb/tb_id_stage.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defs.sv
// RV32I decode constants shared by the decode stage and its consumers:
// opcodes, ALU op codes, writeback selects, immediate formats and the ID/EX bundle.
package riscv_defs;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_SLL    = 4'd2;
   localparam logic [3:0] ALU_SLT    = 4'd3;
   localparam logic [3:0] ALU_SLTU   = 4'd4;
   localparam logic [3:0] ALU_XOR    = 4'd5;
   localparam logic [3:0] ALU_SRL    = 4'd6;
   localparam logic [3:0] ALU_SRA    = 4'd7;
   localparam logic [3:0] ALU_OR     = 4'd8;
   localparam logic [3:0] ALU_AND    = 4'd9;
   localparam logic [3:0] ALU_PASS_B = 4'd10;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] pc_add4;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [3:0]  alu_op;
      logic        alu_src_a;
      logic        alu_src_b;
      logic        mem_read;
      logic        mem_write;
      logic [2:0]  mem_size;
      logic        reg_write;
      logic [1:0]  wb_sel;
      logic        branch;
      logic        jalr;
      logic        illegal;
      logic        exc_addr;
   } idex_t;

   function automatic logic [31:0] gen_imm(input imm_type_e t, input logic [31:0] in);
      logic [31:0] imm;
      case (t)
         IMM_I:   imm = {{20{in[31]}}, in[31:20]};
         IMM_S:   imm = {{20{in[31]}}, in[31:25], in[11:7]};
         IMM_B:   imm = {{20{in[31]}}, in[7], in[30:25], in[11:8], 1'b0};
         IMM_U:   imm = {in[31:12], 12'h000};
         IMM_J:   imm = {{12{in[31]}}, in[19:12], in[20], in[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

   // alt selects SUB for funct3=000 and SRA for funct3=101
   function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
      logic [3:0] op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two async read ports, one sync write port, sync clear.
// Reads return same-cycle write data; x0 is hardwired to zero.
module reg_file
   import riscv_defs::*;
(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [4:0]  i_rs1_addr,
   input  logic [4:0]  i_rs2_addr,
   output logic [31:0] o_rs1_dat,
   output logic [31:0] o_rs2_dat,
   input  logic        i_we,
   input  logic [4:0]  i_rd_addr,
   input  logic [31:0] i_rd_dat
);

   logic [31:0] r_regs [32];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      end else if (i_we && i_rd_addr != 5'd0) begin
         r_regs[i_rd_addr] <= i_rd_dat;
      end
   end

   always_comb begin
      o_rs1_dat = r_regs[i_rs1_addr];
      if (i_rs1_addr == 5'd0)                        o_rs1_dat = '0;
      else if (i_we && i_rd_addr == i_rs1_addr)      o_rs1_dat = i_rd_dat;
      o_rs2_dat = r_regs[i_rs2_addr];
      if (i_rs2_addr == 5'd0)                        o_rs2_dat = '0;
      else if (i_we && i_rd_addr == i_rs2_addr)      o_rs2_dat = i_rd_dat;
   end

endmodule

// File: rtl/id_stage.sv
// RV32I decode: regfile read with WB bypass, immediates, early JAL, load-use detect.
// One cycle into ID/EX; ex_stall_i holds ID/EX, id_stall_o holds fetch on a load-use.
module id_stage
   import riscv_defs::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] id_instruction_i,
   input  logic [31:0] id_pc_i,
   input  logic [31:0] id_pc_add4_i,
   input  logic        id_ready_i,
   input  logic        id_exc_addr_i,
   input  logic        wb_we_i,
   input  logic [4:0]  wb_rd_i,
   input  logic [31:0] wb_data_i,
   input  logic        ex_stall_i,
   input  logic        flush_i,
   output logic        id_stall_o,
   output logic        id_jump_o,
   output logic [31:0] id_jump_address_o,
   output logic        ex_valid_o,
   output logic [31:0] ex_pc_o,
   output logic [31:0] ex_pc_add4_o,
   output logic [31:0] ex_rs1_data_o,
   output logic [31:0] ex_rs2_data_o,
   output logic [31:0] ex_imm_o,
   output logic [4:0]  ex_rs1_o,
   output logic [4:0]  ex_rs2_o,
   output logic [4:0]  ex_rd_o,
   output logic [3:0]  ex_alu_op_o,
   output logic        ex_alu_src_a_o,
   output logic        ex_alu_src_b_o,
   output logic        ex_mem_read_o,
   output logic        ex_mem_write_o,
   output logic [2:0]  ex_mem_size_o,
   output logic        ex_reg_write_o,
   output logic [1:0]  ex_wb_sel_o,
   output logic        ex_branch_o,
   output logic        ex_jalr_o,
   output logic        ex_illegal_o,
   output logic        ex_exc_addr_o
);

   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [6:0]  w_funct7;
   logic [4:0]  w_rs1, w_rs2, w_rd;
   logic [31:0] w_rs1_data, w_rs2_data, w_imm;
   logic        w_legal, w_use_rs1, w_use_rs2;
   imm_type_e   w_imm_type;
   logic [3:0]  w_alu_op;
   logic        w_src_a, w_src_b, w_mem_read, w_mem_write, w_reg_write, w_branch, w_jalr;
   logic [1:0]  w_wb_sel;
   logic        w_load_use;
   idex_t       w_load, w_kill, r_idex;

   assign w_opcode = id_instruction_i[6:0];
   assign w_funct3 = id_instruction_i[14:12];
   assign w_funct7 = id_instruction_i[31:25];
   assign w_rs1    = id_instruction_i[19:15];
   assign w_rs2    = id_instruction_i[24:20];
   assign w_rd     = id_instruction_i[11:7];

   reg_file u_reg_file (
      .i_clk      (clk_i),
      .i_rst_n    (rst_i),
      .i_rs1_addr (w_rs1),
      .i_rs2_addr (w_rs2),
      .o_rs1_dat  (w_rs1_data),
      .o_rs2_dat  (w_rs2_data),
      .i_we       (wb_we_i),
      .i_rd_addr  (wb_rd_i),
      .i_rd_dat   (wb_data_i)
   );

   always_comb begin
      w_legal     = 1'b1;
      w_use_rs1   = 1'b0;
      w_use_rs2   = 1'b0;
      w_imm_type  = IMM_NONE;
      w_alu_op    = ALU_ADD;
      w_src_a     = 1'b0;
      w_src_b     = 1'b0;
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_reg_write = 1'b0;
      w_wb_sel    = WB_ALU;
      w_branch    = 1'b0;
      w_jalr      = 1'b0;
      case (w_opcode)
         OPC_LUI: begin
            w_imm_type = IMM_U; w_alu_op = ALU_PASS_B; w_src_b = 1'b1; w_reg_write = 1'b1;
         end
         OPC_AUIPC: begin
            w_imm_type = IMM_U; w_src_a = 1'b1; w_src_b = 1'b1; w_reg_write = 1'b1;
         end
         OPC_JAL: begin
            w_imm_type = IMM_J; w_src_a = 1'b1; w_src_b = 1'b1; w_reg_write = 1'b1;
            w_wb_sel = WB_PC4;
         end
         OPC_JALR: begin
            w_legal = (w_funct3 == 3'b000);
            w_imm_type = IMM_I; w_use_rs1 = 1'b1; w_src_b = 1'b1; w_reg_write = 1'b1;
            w_wb_sel = WB_PC4; w_jalr = 1'b1;
         end
         OPC_BRANCH: begin
            w_legal = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
            w_imm_type = IMM_B; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
            w_alu_op = ALU_SUB; w_branch = 1'b1;
         end
         OPC_LOAD: begin
            w_legal = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) && (w_funct3 != 3'b111);
            w_imm_type = IMM_I; w_use_rs1 = 1'b1; w_src_b = 1'b1;
            w_mem_read = 1'b1; w_reg_write = 1'b1; w_wb_sel = WB_MEM;
         end
         OPC_STORE: begin
            w_legal = (w_funct3[2] == 1'b0) && (w_funct3 != 3'b011);
            w_imm_type = IMM_S; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_src_b = 1'b1;
            w_mem_write = 1'b1;
         end
         OPC_OP_IMM: begin
            // funct7 field is only constrained for the shift-immediate forms
            if (w_funct3 == 3'b001)      w_legal = (w_funct7 == 7'h00);
            else if (w_funct3 == 3'b101) w_legal = (w_funct7 == 7'h00) || (w_funct7 == 7'h20);
            w_imm_type = IMM_I; w_use_rs1 = 1'b1; w_src_b = 1'b1; w_reg_write = 1'b1;
            w_alu_op = alu_decode(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
         end
         OPC_OP: begin
            w_legal = (w_funct7 == 7'h00) ||
                      ((w_funct7 == 7'h20) && (w_funct3 == 3'b000 || w_funct3 == 3'b101));
            w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_reg_write = 1'b1;
            w_alu_op = alu_decode(w_funct3, w_funct7[5]);
         end
         OPC_FENCE: begin
            w_legal = (w_funct3 == 3'b000); w_imm_type = IMM_I;
         end
         OPC_SYSTEM: begin
            w_legal = (id_instruction_i == 32'h0000_0073) || (id_instruction_i == 32'h0010_0073);
            w_imm_type = IMM_I;
         end
         default: w_legal = 1'b0;
      endcase
   end

   assign w_imm             = gen_imm(w_imm_type, id_instruction_i);
   assign id_jump_address_o = id_pc_i + gen_imm(IMM_J, id_instruction_i);

   assign w_load_use = id_ready_i & r_idex.valid & r_idex.mem_read & (r_idex.rd != 5'd0) &
                       ((w_use_rs1 & (r_idex.rd == w_rs1)) | (w_use_rs2 & (r_idex.rd == w_rs2)));
   assign id_stall_o = w_load_use & ~flush_i;
   assign id_jump_o  = id_ready_i & (w_opcode == OPC_JAL) & ~id_stall_o & ~flush_i;

   always_comb begin
      w_load           = '0;
      w_load.valid     = 1'b1;
      w_load.pc        = id_pc_i;
      w_load.pc_add4   = id_pc_add4_i;
      w_load.rs1_data  = w_rs1_data;
      w_load.rs2_data  = w_rs2_data;
      w_load.imm       = w_imm;
      w_load.rs1       = w_rs1;
      w_load.rs2       = w_rs2;
      w_load.rd        = w_rd;
      w_load.alu_op    = w_alu_op;
      w_load.alu_src_a = w_src_a;
      w_load.alu_src_b = w_src_b;
      w_load.mem_read  = w_mem_read & w_legal;
      w_load.mem_write = w_mem_write & w_legal;
      w_load.mem_size  = w_funct3;
      w_load.reg_write = w_reg_write & w_legal;
      w_load.wb_sel    = w_wb_sel;
      w_load.branch    = w_branch & w_legal;
      w_load.jalr      = w_jalr & w_legal;
      w_load.illegal   = ~w_legal;
      w_load.exc_addr  = id_exc_addr_i;
      // bubble: only the side-effecting controls matter downstream
      w_kill           = w_load;
      w_kill.valid     = 1'b0;
      w_kill.mem_read  = 1'b0;
      w_kill.mem_write = 1'b0;
      w_kill.reg_write = 1'b0;
      w_kill.branch    = 1'b0;
      w_kill.jalr      = 1'b0;
      w_kill.illegal   = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_idex         <= '0;
         r_idex.pc      <= RESET_PC;
         r_idex.pc_add4 <= RESET_PC + 32'd4;
      end else if (flush_i) begin
         r_idex <= w_kill;
      end else if (ex_stall_i) begin
         r_idex <= r_idex;
      end else if (w_load_use || !id_ready_i) begin
         r_idex <= w_kill;
      end else begin
         r_idex <= w_load;
      end
   end

   assign ex_valid_o     = r_idex.valid;
   assign ex_pc_o        = r_idex.pc;
   assign ex_pc_add4_o   = r_idex.pc_add4;
   assign ex_rs1_data_o  = r_idex.rs1_data;
   assign ex_rs2_data_o  = r_idex.rs2_data;
   assign ex_imm_o       = r_idex.imm;
   assign ex_rs1_o       = r_idex.rs1;
   assign ex_rs2_o       = r_idex.rs2;
   assign ex_rd_o        = r_idex.rd;
   assign ex_alu_op_o    = r_idex.alu_op;
   assign ex_alu_src_a_o = r_idex.alu_src_a;
   assign ex_alu_src_b_o = r_idex.alu_src_b;
   assign ex_mem_read_o  = r_idex.mem_read;
   assign ex_mem_write_o = r_idex.mem_write;
   assign ex_mem_size_o  = r_idex.mem_size;
   assign ex_reg_write_o = r_idex.reg_write;
   assign ex_wb_sel_o    = r_idex.wb_sel;
   assign ex_branch_o    = r_idex.branch;
   assign ex_jalr_o      = r_idex.jalr;
   assign ex_illegal_o   = r_idex.illegal;
   assign ex_exc_addr_o  = r_idex.exc_addr;

endmodule

// File: tb/tb_id_stage.sv
// Randomized bench for id_stage against an instruction-level reference model.
module tb_id_stage;
   import riscv_defs::*;

   localparam logic [31:0] RST_PC = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] inst = '0, pc = '0, pc4 = '0, wdata = '0;
   logic        ready = 1'b0, exc = 1'b0, we = 1'b0, ex_stall = 1'b0, flush = 1'b0;
   logic [4:0]  wrd = '0;
   logic        id_stall, id_jump, ex_valid, src_a, src_b, mrd, mwr, rwr, br, jr, ill, exa;
   logic [31:0] jaddr, ex_pc, ex_pc4, d1, d2, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [3:0]  alu;
   logic [2:0]  msz;
   logic [1:0]  wbs;

   id_stage #(.RESET_PC(RST_PC)) dut (
      .clk_i(clk), .rst_i(rst), .id_instruction_i(inst), .id_pc_i(pc), .id_pc_add4_i(pc4),
      .id_ready_i(ready), .id_exc_addr_i(exc), .wb_we_i(we), .wb_rd_i(wrd), .wb_data_i(wdata),
      .ex_stall_i(ex_stall), .flush_i(flush), .id_stall_o(id_stall), .id_jump_o(id_jump),
      .id_jump_address_o(jaddr), .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_pc_add4_o(ex_pc4),
      .ex_rs1_data_o(d1), .ex_rs2_data_o(d2), .ex_imm_o(ex_imm), .ex_rs1_o(ex_rs1),
      .ex_rs2_o(ex_rs2), .ex_rd_o(ex_rd), .ex_alu_op_o(alu), .ex_alu_src_a_o(src_a),
      .ex_alu_src_b_o(src_b), .ex_mem_read_o(mrd), .ex_mem_write_o(mwr), .ex_mem_size_o(msz),
      .ex_reg_write_o(rwr), .ex_wb_sel_o(wbs), .ex_branch_o(br), .ex_jalr_o(jr),
      .ex_illegal_o(ill), .ex_exc_addr_o(exa)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        legal, u1, u2;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic        a, b, mr, mw, rw, br, jr;
      logic [1:0]  wb;
   } dec_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc, pc4, d1, d2, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [3:0]  alu;
      logic        a, b, mr, mw;
      logic [2:0]  sz;
      logic        rw;
      logic [1:0]  wb;
      logic        br, jr, ill, exc;
   } ex_t;

   int          n_checks = 0;
   int          n_fail = 0;
   ex_t         m;
   logic [31:0] mregs [32];
   logic        last_stall, last_jump, m_stall;
   logic [31:0] last_jaddr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] imm_j(input logic [31:0] in);
      logic [20:0] j = {in[31], in[19:12], in[20], in[30:21], 1'b0};
      return 32'($signed(j));
   endfunction

   // Instruction semantics from the ISA tables, one opcode at a time
   function automatic dec_t mdec(input logic [31:0] in);
      dec_t        d;
      logic [2:0]  f3 = in[14:12];
      logic [6:0]  f7 = in[31:25];
      logic [11:0] s12 = {in[31:25], in[11:7]};
      logic [12:0] b13 = {in[31], in[7], in[30:25], in[11:8], 1'b0};
      logic [31:0] ii = 32'($signed(in[31:20]));
      logic [3:0]  tab [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      d = '0;
      d.legal = 1'b1;
      d.alu = ALU_ADD;
      case (in[6:0])
         7'h37: begin d.imm = in & 32'hFFFF_F000; d.alu = ALU_PASS_B; d.b = 1; d.rw = 1; end
         7'h17: begin d.imm = in & 32'hFFFF_F000; d.a = 1; d.b = 1; d.rw = 1; end
         7'h6F: begin d.imm = imm_j(in); d.a = 1; d.b = 1; d.rw = 1; d.wb = 2; end
         7'h67: begin d.legal = (f3 == 0); d.imm = ii; d.u1 = 1; d.b = 1; d.rw = 1; d.wb = 2; d.jr = 1; end
         7'h63: begin
            d.legal = f3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
            d.imm = 32'($signed(b13)); d.u1 = 1; d.u2 = 1; d.br = 1; d.alu = ALU_SUB;
         end
         7'h03: begin
            d.legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            d.imm = ii; d.u1 = 1; d.b = 1; d.mr = 1; d.rw = 1; d.wb = 1;
         end
         7'h23: begin
            d.legal = f3 inside {3'd0, 3'd1, 3'd2};
            d.imm = 32'($signed(s12)); d.u1 = 1; d.u2 = 1; d.b = 1; d.mw = 1;
         end
         7'h13: begin
            d.imm = ii; d.u1 = 1; d.b = 1; d.rw = 1; d.alu = tab[f3];
            if (f3 == 1) d.legal = (f7 == 0);
            if (f3 == 5) d.legal = (f7 == 0) || (f7 == 7'h20);
            if (f3 == 5 && f7 == 7'h20) d.alu = ALU_SRA;
         end
         7'h33: begin
            d.u1 = 1; d.u2 = 1; d.rw = 1; d.alu = tab[f3];
            d.legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
            if (f7 == 7'h20 && f3 == 0) d.alu = ALU_SUB;
            if (f7 == 7'h20 && f3 == 5) d.alu = ALU_SRA;
         end
         7'h0F: begin d.legal = (f3 == 0); d.imm = ii; end
         7'h73: begin d.legal = (in == 32'h73) || (in == 32'h0010_0073); d.imm = ii; end
         default: d.legal = 1'b0;
      endcase
      if (!d.legal) begin d.mr = 0; d.mw = 0; d.rw = 0; d.br = 0; d.jr = 0; end
      return d;
   endfunction

   function automatic logic [31:0] mread(input logic [4:0] a);
      if (a == 0) return '0;
      if (we && wrd == a) return wdata;
      return mregs[a];
   endfunction

   function automatic ex_t bubble(input ex_t e);
      ex_t b = e;
      b.valid = 0; b.rw = 0; b.mr = 0; b.mw = 0; b.br = 0; b.jr = 0; b.ill = 0;
      return b;
   endfunction

   task automatic cmp_ex();
      check("ex_valid", ex_valid, m.valid);
      check("ex_reg_write", rwr, m.rw);
      check("ex_mem_read", mrd, m.mr);
      check("ex_mem_write", mwr, m.mw);
      check("ex_branch", br, m.br);
      check("ex_jalr", jr, m.jr);
      check("ex_illegal", ill, m.ill);
      if (m.valid) begin
         check("ex_pc", ex_pc, m.pc);
         check("ex_pc_add4", ex_pc4, m.pc4);
         check("ex_rs1_data", d1, m.d1);
         check("ex_rs2_data", d2, m.d2);
         check("ex_regidx", {ex_rs1, ex_rs2, ex_rd}, {m.rs1, m.rs2, m.rd});
         check("ex_mem_size", msz, m.sz);
         check("ex_exc_addr", exa, m.exc);
         if (!m.ill) begin
            check("ex_imm", ex_imm, m.imm);
            check("ex_alu_op", alu, m.alu);
            check("ex_src_ab", {src_a, src_b}, {m.a, m.b});
            check("ex_wb_sel", wbs, m.wb);
         end
      end
   endtask

   // Called at negedge: apply inputs, check combinational outputs, clock, check ID/EX.
   task automatic step(input logic [31:0] i_inst, input logic [31:0] i_pc, input logic i_rdy,
                       input logic i_exc, input logic i_we, input logic [4:0] i_wrd,
                       input logic [31:0] i_wd, input logic i_stall, input logic i_flush);
      dec_t d;
      ex_t  nx;
      logic jmp;
      inst = i_inst; pc = i_pc; pc4 = i_pc + 32'd4; ready = i_rdy; exc = i_exc;
      we = i_we; wrd = i_wrd; wdata = i_wd; ex_stall = i_stall; flush = i_flush;
      #1;
      d = mdec(i_inst);
      m_stall = i_rdy && m.valid && m.mr && m.rd != 0 && !i_flush &&
                ((d.u1 && m.rd == i_inst[19:15]) || (d.u2 && m.rd == i_inst[24:20]));
      jmp = i_rdy && i_inst[6:0] == 7'h6F && !m_stall && !i_flush;
      last_stall = id_stall; last_jump = id_jump; last_jaddr = jaddr;
      check("id_stall", id_stall, m_stall);
      check("id_jump", id_jump, jmp);
      check("id_jump_address", jaddr, i_pc + imm_j(i_inst));
      nx = m;
      if (i_flush) nx = bubble(m);
      else if (i_stall) nx = m;
      else if (m_stall || !i_rdy) nx = bubble(m);
      else begin
         nx = '0;
         nx.valid = 1; nx.pc = i_pc; nx.pc4 = i_pc + 32'd4;
         nx.d1 = mread(i_inst[19:15]); nx.d2 = mread(i_inst[24:20]);
         nx.imm = d.imm; nx.rs1 = i_inst[19:15]; nx.rs2 = i_inst[24:20]; nx.rd = i_inst[11:7];
         nx.alu = d.alu; nx.a = d.a; nx.b = d.b; nx.mr = d.mr; nx.mw = d.mw;
         nx.sz = i_inst[14:12]; nx.rw = d.rw; nx.wb = d.wb; nx.br = d.br; nx.jr = d.jr;
         nx.ill = !d.legal; nx.exc = i_exc;
      end
      @(posedge clk);
      if (i_we && i_wrd != 0) mregs[i_wrd] = i_wd;
      m = nx;
      @(negedge clk);
      cmp_ex();
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] w = $urandom;
      int k = $urandom_range(0, 13);
      if (k == 13) return 32'hFFFF_FFFF;
      if (k >= 11) return w;
      case (k)
         0: w[6:0] = 7'h37;  1: w[6:0] = 7'h17;  2: w[6:0] = 7'h6F;  3: w[6:0] = 7'h67;
         4: w[6:0] = 7'h63;  5: w[6:0] = 7'h03;  6: w[6:0] = 7'h23;  7: w[6:0] = 7'h13;
         8: w[6:0] = 7'h33;  9: w[6:0] = 7'h0F;  default: w[6:0] = 7'h73;
      endcase
      w[11:7]  = 5'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      if (k == 10 && $urandom_range(0, 1) != 0) w = 32'h0000_0073;
      return w;
   endfunction

   initial begin
      logic [31:0] r_inst, r_pc;
      for (int i = 0; i < 32; i++) mregs[i] = '0;
      m = '0; m.pc = RST_PC; m.pc4 = RST_PC + 32'd4;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ex_valid", ex_valid, 0);
      check("rst_ex_pc", ex_pc, RST_PC);
      check("rst_ex_pc_add4", ex_pc4, RST_PC + 32'd4);
      check("rst_id_stall", id_stall, 0);
      check("rst_ctrl", {rwr, mrd, mwr, br, jr, ill, exa, src_a, src_b}, 0);
      check("rst_data", d1 | d2 | ex_imm, 0);
      check("rst_fields", {ex_rs1, ex_rs2, ex_rd, alu, msz, wbs}, 0);
      rst = 1'b1;

      step(32'h0050_0093, 32'h100, 1, 0, 0, 0, 0, 0, 0);
      check("addi_valid", ex_valid, 1);
      check("addi_rd", ex_rd, 1);
      check("addi_imm", ex_imm, 5);
      check("addi_rw_srcb", {rwr, src_b}, 2'b11);
      check("addi_pc", ex_pc, 32'h100);

      step(32'h0031_8233, 32'h104, 1, 0, 1, 3, 32'hDEAD_BEEF, 0, 0);
      check("bypass_rs1", d1, 32'hDEAD_BEEF);
      check("bypass_rs2", d2, 32'hDEAD_BEEF);
      step(32'h0000_0233, 32'h108, 1, 0, 1, 0, 32'h1234_5678, 0, 0);
      check("x0_bypass", d1, 0);
      step(32'h0000_0233, 32'h10C, 1, 0, 0, 0, 0, 0, 0);
      check("x0_write", d1, 0);

      step(32'h0001_2283, 32'h120, 1, 0, 0, 0, 0, 0, 0);
      step(32'h0012_8333, 32'h124, 1, 0, 0, 0, 0, 0, 0);
      check("lu_stall", last_stall, 1);
      check("lu_bubble", ex_valid, 0);
      step(32'h0012_8333, 32'h124, 1, 0, 0, 0, 0, 0, 0);
      check("lu_release", last_stall, 0);
      check("lu_add_rs1", ex_rs1, 5);
      check("lu_add_valid", ex_valid, 1);

      step(32'h0100_00EF, 32'h200, 1, 0, 0, 0, 0, 0, 0);
      check("jal_jump", last_jump, 1);
      check("jal_addr", last_jaddr, 32'h210);
      check("jal_wb_sel", wbs, 2);
      check("jal_pc_add4", ex_pc4, 32'h204);
      check("jal_rd", ex_rd, 1);

      step(32'h0070_0393, 32'h300, 1, 0, 0, 0, 0, 1, 1);
      check("flush_over_stall", ex_valid, 0);
      step(32'hFFFF_FFFF, 32'h304, 1, 0, 0, 0, 0, 0, 0);
      check("illegal", ill, 1);
      check("illegal_side_fx", {rwr, mrd, mwr}, 0);
      step(32'h0070_0393, 32'h308, 1, 0, 0, 0, 0, 0, 0);
      step(32'h0000_0233, 32'h30C, 1, 0, 0, 0, 0, 1, 0);
      check("ex_stall_hold", ex_pc, 32'h308);

      r_inst = rand_inst();
      r_pc = 32'h400;
      for (int n = 0; n < 3000; n++) begin
         logic rdy, stl, fl, wen;
         rdy = ($urandom_range(0, 7) != 0);
         stl = ($urandom_range(0, 7) == 0);
         fl  = ($urandom_range(0, 15) == 0);
         wen = ($urandom_range(0, 1) != 0);
         step(r_inst, r_pc, rdy, ($urandom_range(0, 31) == 0), wen, 5'($urandom_range(0, 7)),
              $urandom, stl, fl);
         if (!m_stall && !stl) begin
            r_inst = rand_inst();
            r_pc = r_pc + 32'd4;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
